// File: rtl/msrv32_wb_pipe_unit.sv
// msrv32_wb_pipe_unit: registered write-back stage for the msrv32 core.
// Chooses one of NUM_SRC results per retiring instruction and drives a
// single-cycle register-file write port. A short history of recent writes
// forwards operands to two read ports, and the ALU second-operand select
// uses the forwarded rs2.
// Optional feature macro: MSRV32_WB_INSTRET_EN (64-bit retired-instruction
// counter on instret_out; when undefined, instret_out is tied to 0).
module msrv32_wb_pipe_unit #(
   parameter int XLEN      = 32,
   parameter int NUM_SRC   = 6,
   parameter int SEL_W     = 3,
   parameter int FWD_DEPTH = 2
) (
   input  logic                    ms_riscv32_mp_clk_in,
   input  logic                    ms_riscv32_mp_rst_in,
   input  logic [NUM_SRC*XLEN-1:0] src_data_in,
   input  logic [SEL_W-1:0]        wb_mux_sel_in,
   input  logic [4:0]              rd_addr_in,
   input  logic                    wr_en_in,
   input  logic                    valid_in,
   output logic                    ready_out,
   input  logic                    hold_in,
   input  logic                    flush_in,
   input  logic [4:0]              rs1_addr_in,
   input  logic [4:0]              rs2_addr_in,
   input  logic [XLEN-1:0]         rs1_data_in,
   input  logic [XLEN-1:0]         rs2_data_in,
   input  logic [XLEN-1:0]         imm_in,
   input  logic                    alu_src_in,
   output logic [XLEN-1:0]         rs1_fwd_out,
   output logic [XLEN-1:0]         rs2_fwd_out,
   output logic [XLEN-1:0]         alu_2nd_src_out,
   output logic                    rf_wr_en_out,
   output logic [4:0]              rf_wr_addr_out,
   output logic [XLEN-1:0]         rf_wr_data_out,
   output logic [63:0]             instret_out
);

   logic            acc;
   logic            push;
   logic [XLEN-1:0] mux_data;

   // Write-back history, entry 0 is the newest committed write.
   logic [FWD_DEPTH-1:0]            hist_v;
   logic [FWD_DEPTH-1:0][4:0]       hist_addr;
   logic [FWD_DEPTH-1:0][XLEN-1:0]  hist_data;

   assign ready_out = !hold_in;
   assign acc       = valid_in & ready_out & !flush_in;
   // Writes to x0 are dropped, so they never reach the port or the history.
   assign push      = acc & wr_en_in & (rd_addr_in != 5'd0);

   // Source mux; an out-of-range select falls back to the ALU result (source 0).
   always_comb begin
      mux_data = src_data_in[XLEN-1:0];
      for (int k = 1; k < NUM_SRC; k++) begin
         if (wb_mux_sel_in == SEL_W'(k)) mux_data = src_data_in[k*XLEN +: XLEN];
      end
   end

   // Register-file write port: strobe lasts one cycle, addr/data hold otherwise.
   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (ms_riscv32_mp_rst_in) begin
         rf_wr_en_out   <= 1'b0;
         rf_wr_addr_out <= 5'd0;
         rf_wr_data_out <= '0;
      end else begin
         rf_wr_en_out <= 1'b0;
         if (acc) begin
            rf_wr_en_out   <= push;
            rf_wr_addr_out <= rd_addr_in;
            rf_wr_data_out <= mux_data;
         end
      end
   end

   // History shift register: advances only when a real write commits.
   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (ms_riscv32_mp_rst_in) begin
         hist_v    <= '0;
         hist_addr <= '0;
         hist_data <= '0;
      end else if (push) begin
         for (int i = FWD_DEPTH-1; i > 0; i--) begin
            hist_v[i]    <= hist_v[i-1];
            hist_addr[i] <= hist_addr[i-1];
            hist_data[i] <= hist_data[i-1];
         end
         hist_v[0]    <= 1'b1;
         hist_addr[0] <= rd_addr_in;
         hist_data[0] <= mux_data;
      end
   end

   // Operand forwarding: scan oldest to newest so the newest hit wins; x0 reads 0.
   always_comb begin
      rs1_fwd_out = rs1_data_in;
      rs2_fwd_out = rs2_data_in;
      for (int i = FWD_DEPTH-1; i >= 0; i--) begin
         if (hist_v[i] && (hist_addr[i] == rs1_addr_in)) rs1_fwd_out = hist_data[i];
         if (hist_v[i] && (hist_addr[i] == rs2_addr_in)) rs2_fwd_out = hist_data[i];
      end
      if (rs1_addr_in == 5'd0) rs1_fwd_out = '0;
      if (rs2_addr_in == 5'd0) rs2_fwd_out = '0;
   end

   assign alu_2nd_src_out = alu_src_in ? rs2_fwd_out : imm_in;

`ifdef MSRV32_WB_INSTRET_EN
   logic [63:0] instret_q;

   // Retired-instruction counter: every accepted instruction counts, wraps at 2**64.
   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (ms_riscv32_mp_rst_in) instret_q <= 64'd0;
      else if (acc)             instret_q <= instret_q + 64'd1;
   end

   assign instret_out = instret_q;
`else
   assign instret_out = 64'd0;
`endif

endmodule

// File: tb/tb_msrv32_wb_pipe_unit.sv
// Randomized self-checking bench for msrv32_wb_pipe_unit with a queue-based
// reference model of the write port, forwarding history and instret.
module tb_msrv32_wb_pipe_unit;
   localparam int XLEN = 32, NUM_SRC = 6, SEL_W = 3, FWD_DEPTH = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NUM_SRC*XLEN-1:0] src_data = '0;
   logic [SEL_W-1:0] sel = '0;
   logic [4:0] rd = '0, rs1_addr = '0, rs2_addr = '0;
   logic wr_en = 1'b0, valid = 1'b0, hold = 1'b0, flush = 1'b0, alu_src = 1'b0;
   logic [XLEN-1:0] rs1_data = '0, rs2_data = '0, imm = '0;
   logic ready, rf_wr_en;
   logic [4:0] rf_wr_addr;
   logic [XLEN-1:0] rs1_fwd, rs2_fwd, alu2, rf_wr_data;
   logic [63:0] instret;

   always #5 clk = ~clk;

   msrv32_wb_pipe_unit #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .FWD_DEPTH(FWD_DEPTH)) dut (
      .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
      .src_data_in(src_data), .wb_mux_sel_in(sel), .rd_addr_in(rd),
      .wr_en_in(wr_en), .valid_in(valid), .ready_out(ready),
      .hold_in(hold), .flush_in(flush),
      .rs1_addr_in(rs1_addr), .rs2_addr_in(rs2_addr),
      .rs1_data_in(rs1_data), .rs2_data_in(rs2_data),
      .imm_in(imm), .alu_src_in(alu_src),
      .rs1_fwd_out(rs1_fwd), .rs2_fwd_out(rs2_fwd), .alu_2nd_src_out(alu2),
      .rf_wr_en_out(rf_wr_en), .rf_wr_addr_out(rf_wr_addr), .rf_wr_data_out(rf_wr_data),
      .instret_out(instret)
   );

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: list of committed writes, newest first.
   typedef struct { logic [4:0] a; logic [XLEN-1:0] d; } wb_t;
   wb_t hist[$];
   logic [63:0] m_cnt = 0;
   logic m_wen = 0;
   logic [4:0] m_addr = 0;
   logic [XLEN-1:0] m_data = 0;

   function automatic logic [XLEN-1:0] ref_fwd(input logic [4:0] a, input logic [XLEN-1:0] d);
      if (a == 0) return '0;
      for (int i = 0; i < hist.size() && i < FWD_DEPTH; i++)
         if (hist[i].a == a) return hist[i].d;
      return d;
   endfunction

   function automatic logic [63:0] exp_instret();
`ifdef MSRV32_WB_INSTRET_EN
      return m_cnt;
`else
      return 64'd0;
`endif
   endfunction

   // One clock: check combinational outputs, advance model, check registered outputs.
   task automatic cycle();
      bit acc;
      int s;
      logic [XLEN-1:0] val;
      #1;
      chk("ready", 64'(ready), 64'(!hold));
      chk("rs1_fwd", 64'(rs1_fwd), 64'(ref_fwd(rs1_addr, rs1_data)));
      chk("rs2_fwd", 64'(rs2_fwd), 64'(ref_fwd(rs2_addr, rs2_data)));
      chk("alu2", 64'(alu2), 64'(alu_src ? ref_fwd(rs2_addr, rs2_data) : imm));
      acc = valid && !hold && !flush;
      s = int'(sel);
      if (s >= NUM_SRC) s = 0;
      val = src_data[s*XLEN +: XLEN];
      if (rst) begin
         m_wen = 0; m_addr = 0; m_data = 0; m_cnt = 0;
         hist.delete();
      end else if (acc) begin
         m_wen = wr_en && (rd != 0);
         m_addr = rd; m_data = val;
         m_cnt++;
         if (m_wen) begin
            hist.push_front('{a: rd, d: val});
            if (hist.size() > FWD_DEPTH) void'(hist.pop_back());
         end
      end else m_wen = 0;
      @(posedge clk); #1;
      chk("wr_en", 64'(rf_wr_en), 64'(m_wen));
      chk("wr_addr", 64'(rf_wr_addr), 64'(m_addr));
      chk("wr_data", 64'(rf_wr_data), 64'(m_data));
      chk("instret", instret, exp_instret());
   endtask

   // Present one instruction; 'd' lands in the slot the select actually picks.
   task automatic issue(input bit v, input int sl, input int r, input bit we,
                        input bit h, input bit f, input logic [XLEN-1:0] d);
      for (int k = 0; k < NUM_SRC; k++) src_data[k*XLEN +: XLEN] = $urandom;
      src_data[((sl < NUM_SRC) ? sl : 0)*XLEN +: XLEN] = d;
      valid = v; sel = SEL_W'(sl); rd = 5'(r); wr_en = we; hold = h; flush = f;
      cycle();
   endtask

   task automatic idle();
      issue(0, 0, 0, 0, 0, 0, '0);
   endtask

   initial begin
      int codes[15] = '{0,0,1,0,2,0,0,2,1,0,0,2,0,0,0};
      // Reset state
      rst = 1; cycle();
      chk("rst_wr_en", 64'(rf_wr_en), 64'd0);
      chk("rst_instret", instret, 64'd0);
      rst = 0;

      // Source select: sel=5 and out-of-range sel=7
      issue(1, 5, 3, 1, 0, 0, 32'h0000_1004);
      chk("sel5_en", 64'(rf_wr_en), 64'd1);
      chk("sel5_data", 64'(rf_wr_data), 64'h1004);
      idle();
      chk("sel5_single_strobe", 64'(rf_wr_en), 64'd0);
      issue(1, 7, 3, 1, 0, 0, 32'hA5);
      chk("sel7_data", 64'(rf_wr_data), 64'hA5);

      // x0 write is dropped; x0 reads 0
      issue(1, 0, 0, 1, 0, 0, 32'hFFFF_FFFF);
      chk("x0_no_strobe", 64'(rf_wr_en), 64'd0);
      rs1_addr = 0; rs1_data = 32'h123; #1;
      chk("x0_fwd", 64'(rs1_fwd), 64'd0);

      // Forwarding priority and eviction
      issue(1, 0, 5, 1, 0, 0, 32'h11);
      issue(1, 0, 5, 1, 0, 0, 32'h22);
      rs1_addr = 5; rs1_data = 32'h99; #1;
      chk("fwd_newest", 64'(rs1_fwd), 64'h22);
      issue(1, 0, 6, 1, 0, 0, 32'h33);
      issue(1, 0, 7, 1, 0, 0, 32'h44);
      chk("fwd_evicted", 64'(rs1_fwd), 64'h99);
      alu_src = 1; rs2_addr = 7; rs2_data = 32'h5; #1;
      chk("alu2_rs2", 64'(alu2), 64'h44);
      alu_src = 0; imm = 32'h8; #1;
      chk("alu2_imm", 64'(alu2), 64'h8);

      // Hold for 3 cycles, then release gives one strobe
      for (int i = 0; i < 3; i++) begin
         issue(1, 0, 10, 1, 1, 0, 32'hBEEF);
         chk("hold_ready", 64'(ready), 64'd0);
         chk("hold_no_strobe", 64'(rf_wr_en), 64'd0);
      end
      issue(1, 0, 10, 1, 0, 0, 32'hBEEF);
      chk("release_strobe", 64'(rf_wr_en), 64'd1);
      idle();
      chk("release_once", 64'(rf_wr_en), 64'd0);

      // Flush: no write, no forwarding
      issue(1, 0, 9, 1, 0, 1, 32'hDEAD);
      chk("flush_no_strobe", 64'(rf_wr_en), 64'd0);
      rs1_addr = 9; rs1_data = 32'h55; #1;
      chk("flush_no_fwd", 64'(rs1_fwd), 64'h55);

      // Mid-stream reset right after a write to x4
      issue(1, 0, 4, 1, 0, 0, 32'h4444);
      rst = 1; issue(1, 0, 4, 1, 0, 0, 32'h4445); rst = 0;
      chk("midrst_en", 64'(rf_wr_en), 64'd0);
      chk("midrst_instret", instret, 64'd0);
      rs1_addr = 4; rs1_data = 32'h77; #1;
      chk("midrst_fwd_miss", 64'(rs1_fwd), 64'h77);

      // Instret: 10 accepts with 2 flushes and 3 holds interleaved
      foreach (codes[i])
         issue(1, $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom),
               codes[i] == 2, codes[i] == 1, $urandom);
      idle();
`ifdef MSRV32_WB_INSTRET_EN
      chk("instret_10", instret, 64'd10);
`else
      chk("instret_off", instret, 64'd0);
`endif

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 49) == 0);
         rs1_addr = 5'($urandom_range(0, 7)); rs2_addr = 5'($urandom_range(0, 7));
         rs1_data = $urandom; rs2_data = $urandom; imm = $urandom; alu_src = 1'($urandom);
         issue($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 5) == 0, $urandom);
      end
      rst = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/msrv32_wb_pipe_unit.md
Name: msrv32_wb_pipe_unit

Overview:
- Parametrised, registered successor of the write-back mux select logic.
- Selects one of NUM_SRC result sources per retiring instruction and registers it into a single-cycle register-file write port.
- Keeps a FWD_DEPTH-entry history of recent write-backs and uses it to forward operands to two read ports.
- Sits between the execute/memory stage and the integer register file; also produces the ALU second-operand select with forwarding applied.

Parameters:
- XLEN, 32, data width of every source and output.
- NUM_SRC, 6, number of write-back sources (0=ALU, 1=LU, 2=IMM, 3=IADDER, 4=CSR, 5=PC+4; extra sources are appended).
- SEL_W, 3, select width; must satisfy 2**SEL_W >= NUM_SRC.
- FWD_DEPTH, 2, number of write-back history entries searched for forwarding; legal range 1..4.

Ports:
- ms_riscv32_mp_clk_in  input  1  clock; all state on rising edge
- ms_riscv32_mp_rst_in  input  1  synchronous, active-high reset
- src_data_in  input  NUM_SRC*XLEN  flattened sources; source k in bits [k*XLEN +: XLEN]
- wb_mux_sel_in  input  SEL_W  source select
- rd_addr_in  input  5  destination register
- wr_en_in  input  1  instruction writes rd
- valid_in  input  1  an instruction is presented
- ready_out  output  1  stage can accept; equals !hold_in
- hold_in  input  1  stall from the hazard/control unit
- flush_in  input  1  discard the presented instruction
- rs1_addr_in, rs2_addr_in  input  5 each  operand lookup addresses
- rs1_data_in, rs2_data_in  input  XLEN each  register-file read data
- imm_in  input  XLEN  immediate operand
- alu_src_in  input  1  1 selects rs2, 0 selects imm
- rs1_fwd_out, rs2_fwd_out  output  XLEN each  operands after forwarding
- alu_2nd_src_out  output  XLEN  alu_src_in ? rs2_fwd_out : imm_in
- rf_wr_en_out  output  1  register-file write strobe
- rf_wr_addr_out  output  5  register-file write address
- rf_wr_data_out  output  XLEN  register-file write data
- instret_out  output  64  retired-instruction count (see Optional Feature)

Behaviour:
- Accept condition: acc = valid_in & ready_out & !flush_in.
- Mux: sel < NUM_SRC selects src[sel]; any out-of-range sel selects src[0] (ALU).
- Write port, 1-cycle latency. On acc:
  - rf_wr_en_out <= wr_en_in & (rd_addr_in != 0)
  - rf_wr_addr_out <= rd_addr_in
  - rf_wr_data_out <= mux result
- When acc=0, rf_wr_en_out <= 0 and addr/data hold their values. Each write strobes for exactly one cycle; hold never repeats a write.
- History: shift register of FWD_DEPTH entries {v, addr, data}.
  - On acc with wr_en_in=1 and rd!=0: entry0 takes the new write and entry[i] <= entry[i-1].
  - Otherwise the history is unchanged (hold, flush, no-write and x0 cycles).
  - Entry0 always mirrors the last committed write.
- Forwarding is combinational, per port: if addr==0, the output is rs_data_in (or 0 if the register file does not hard-wire x0; the block outputs 0 for addr 0). Otherwise the lowest-index (newest) valid entry whose addr matches supplies the data; with no hit, rs_data_in passes through.
- Simultaneous events:
  - flush_in with valid_in: no write, no history push, no count.
  - hold_in with flush_in: nothing is accepted.
  - hold_in blocks acceptance regardless of valid_in.
- Reset, taking priority over acc and effective mid-operation: rf_wr_en_out=0, rf_wr_addr_out=0, rf_wr_data_out=0, all history v=0 (addr/data=0), instret_out=0.
- ready_out and the forwarding outputs are combinational and carry no reset value.

Optional Feature:
- Macro: MSRV32_WB_INSTRET_EN.
- Defined: 64-bit counter, incremented by 1 on every acc (including wr_en_in=0 and rd=x0). Wraps 2**64-1 -> 0. Reset to 0. Drives instret_out.
- Undefined: no counter logic; instret_out is tied to 0.

Test Plan:
- Source select: reset, then valid=1, sel=5, src5=0x0000_1004, rd=3, wr_en=1 -> next cycle rf_wr_en=1, addr=3, data=0x1004; following cycle rf_wr_en=0. Repeat with sel=7 and src0=0xA5 -> data=0xA5.
- x0 and no-write: rd=0 with wr_en=1, data 0xFFFF_FFFF -> rf_wr_en stays 0, history unchanged. Then rs1_addr=0 -> rs1_fwd_out=0.
- Forwarding priority (FWD_DEPTH=2): write x5=0x11 then x5=0x22, rs1_addr=5, rs1_data_in=0x99 -> 0x22. Then write x6=0x33 and x7=0x44 -> rs1 (x5) returns 0x99 (evicted). alu_src=1 with rs2_addr=7 -> alu_2nd_src_out=0x44; alu_src=0, imm=0x8 -> 0x8.
- Hold and flush: hold_in=1 with valid=1 for 3 cycles -> ready_out=0 and no strobe. Release -> exactly one strobe. flush_in=1 with valid=1, rd=9 -> no write, x9 not forwarded.
- Mid-stream reset: reset asserted in the cycle after an accepted write to x4 -> rf_wr_en_out=0, x4 forwarding misses. With MSRV32_WB_INSTRET_EN, instret_out=0.
- Instret (macro defined): 10 accepts with 2 flushed and 3 held cycles interleaved -> instret_out=10. Macro undefined -> instret_out=0 throughout.
